// File: rtl/max7219_sched_if.sv
// Scheduler-side bus: frame buffer writes, raw command handshake and the
// 16-bit word handshake toward the MAX7219 serializer.
interface max7219_sched_if;
  logic        fb_we;
  logic [2:0]  fb_addr;
  logic [7:0]  fb_data;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;
  logic        init_done;
  logic        busy;

  modport master (
    output fb_we, fb_addr, fb_data, cmd_valid, cmd_word, word_ready,
    input  cmd_ready, word_valid, word_data, init_done, busy
  );

  modport slave (
    input  fb_we, fb_addr, fb_data, cmd_valid, cmd_word, word_ready,
    output cmd_ready, word_valid, word_data, init_done, busy
  );
endinterface

// File: rtl/max7219_scheduler.sv
// Shares the MAX7219 command link between the power-up init sequence, external
// raw commands and a dirty-tracked 8-digit frame buffer refresher.
module max7219_scheduler #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter logic [3:0]  INTENSITY     = 4'h0,
  parameter logic [2:0]  SCAN_LIMIT    = 3'd7,
  parameter logic [31:0] REFRESH_TICKS = 32'd1350000
) (
  input  logic           clk,
  input  logic           rst_n,
  max7219_sched_if.slave bus
);

  localparam int unsigned DIGIT_W  = 3;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned TIMER_W  = 32;
  localparam int unsigned INIT_LEN = 5;

  localparam logic [1:0] ST_INIT_LOAD = 2'd0;
  localparam logic [1:0] ST_INIT_SEND = 2'd1;
  localparam logic [1:0] ST_IDLE      = 2'd2;
  localparam logic [1:0] ST_SEND      = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic                        word_valid_q, word_valid_d;
  logic [WORD_W-1:0]           word_data_q, word_data_d;
  logic                        init_done_q, init_done_d;
  logic                        busy_q, busy_d;
  logic                        fair_q, fair_d;
  logic [2:0]                  init_idx_q, init_idx_d;
  logic [TIMER_W-1:0]          timer_q, timer_d;
  logic [NUM_DIGITS-1:0][7:0]  fb_q, fb_d;
  logic [NUM_DIGITS-1:0]       dirty_q, dirty_d;

  logic                        any_dirty;
  logic [DIGIT_W-1:0]          ref_idx;
  logic [3:0]                  ref_addr;
  logic [WORD_W-1:0]           ref_word;
  logic [WORD_W-1:0]           init_word;
  logic                        cmd_grant;
  logic                        ref_grant;
  logic                        word_accept;
  logic                        fb_hit;
  logic                        refresh_tick;

  // Init ROM: shutdown, no-decode, scan limit, intensity, normal operation.
  always_comb begin
    case (init_idx_q)
      3'd0:    init_word = 16'h0C00;
      3'd1:    init_word = 16'h0900;
      3'd2:    init_word = {8'h0B, 5'b0, SCAN_LIMIT};
      3'd3:    init_word = {8'h0A, 4'b0, INTENSITY};
      default: init_word = 16'h0C01;
    endcase
  end

  // Lowest-index dirty digit is the refresh target.
  always_comb begin
    ref_idx = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (dirty_q[i]) ref_idx = DIGIT_W'(i);
    end
  end

  always_comb begin
    any_dirty    = |dirty_q;
    ref_addr     = 4'(ref_idx) + 4'd1;
    ref_word     = {4'h0, ref_addr, fb_q[ref_idx]};
    word_accept  = word_valid_q && bus.word_ready;
    fb_hit       = bus.fb_we && (32'(bus.fb_addr) < 32'(NUM_DIGITS));
    refresh_tick = (timer_q == REFRESH_TICKS - 32'd1);
    cmd_grant    = (state_q == ST_IDLE) && init_done_q && bus.cmd_valid &&
                   (!any_dirty || !fair_q);
    ref_grant    = (state_q == ST_IDLE) && any_dirty &&
                   (!bus.cmd_valid || fair_q);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    init_done_d  = init_done_q;
    init_idx_d   = init_idx_q;
    fair_d       = fair_q;
    fb_d         = fb_q;
    dirty_d      = dirty_q;
    timer_d      = timer_q + 32'd1;

    case (state_q)
      ST_INIT_LOAD: begin
        word_data_d  = init_word;
        word_valid_d = 1'b1;
        state_d      = ST_INIT_SEND;
      end
      ST_INIT_SEND: begin
        if (word_accept) begin
          word_valid_d = 1'b0;
          init_idx_d   = init_idx_q + 3'd1;
          if (init_idx_q == 3'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_INIT_LOAD;
          end
        end
      end
      ST_IDLE: begin
        if (cmd_grant) begin
          word_data_d  = bus.cmd_word;
          word_valid_d = 1'b1;
          fair_d       = 1'b1;
          state_d      = ST_SEND;
        end else if (ref_grant) begin
          word_data_d       = ref_word;
          word_valid_d      = 1'b1;
          fair_d            = 1'b0;
          dirty_d[ref_idx]  = 1'b0;
          state_d           = ST_SEND;
        end
      end
      default: begin
        if (word_accept) begin
          word_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
    endcase

    // A write landing on the grant edge re-marks the digit after the clear.
    if (fb_hit) begin
      fb_d[bus.fb_addr]    = bus.fb_data;
      dirty_d[bus.fb_addr] = 1'b1;
    end

    if (refresh_tick) begin
      timer_d = '0;
      dirty_d = '1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT_LOAD;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      fair_q       <= 1'b0;
      init_idx_q   <= '0;
      timer_q      <= '0;
      fb_q         <= '0;
      dirty_q      <= '1;
    end else begin
      state_q      <= state_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      fair_q       <= fair_d;
      init_idx_q   <= init_idx_d;
      timer_q      <= timer_d;
      fb_q         <= fb_d;
      dirty_q      <= dirty_d;
    end
  end

  assign bus.cmd_ready  = cmd_grant;
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.init_done  = init_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_max7219_scheduler.sv
// Bench for max7219_scheduler: directed scenarios plus random traffic, all
// checked against a transaction-level model of the link sharing rules.
module tb_max7219_scheduler;

  localparam int unsigned ND   = 8;
  localparam int unsigned RT   = 64;
  localparam logic [3:0]  INTY = 4'h0;
  localparam logic [2:0]  SCAN = 3'd7;

  logic clk = 1'b0;
  logic rst_n;

  max7219_sched_if bus();

  max7219_scheduler #(
    .NUM_DIGITS(ND), .INTENSITY(INTY), .SCAN_LIMIT(SCAN), .REFRESH_TICKS(32'(RT))
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: offered word, pending init words, digit contents and dirty marks.
  logic [7:0]  m_fb [ND];
  bit          m_dirty [ND];
  bit          m_fair, m_offer, m_init_done;
  logic [15:0] m_word;
  int unsigned m_timer;
  logic [15:0] m_init_q [$];

  typedef struct { logic [19:0] obs; logic [19:0] exp; } trace_t;
  trace_t      trace [$];
  logic [15:0] obs_words [$];
  logic [15:0] exp_words [$];

  logic        s_valid, s_cready, s_init_done, s_busy;
  logic [15:0] s_data;

  task automatic model_edge();
    int first;
    if (rst_n !== 1'b1) begin
      foreach (m_fb[i]) begin m_fb[i] = 8'h00; m_dirty[i] = 1'b1; end
      m_fair = 0; m_offer = 0; m_init_done = 0; m_word = 16'h0; m_timer = 0;
      m_init_q = '{16'h0C00, 16'h0900, {8'h0B, 5'h0, SCAN}, {8'h0A, 4'h0, INTY}, 16'h0C01};
      return;
    end
    first = -1;
    for (int i = 0; i < int'(ND); i++) if (m_dirty[i] && first < 0) first = i;
    if (m_offer) begin
      if (bus.word_ready === 1'b1) begin
        exp_words.push_back(m_word);
        m_offer = 0;
        if (!m_init_done && m_init_q.size() == 0) m_init_done = 1;
      end
    end else if (!m_init_done) begin
      m_word = m_init_q.pop_front();
      m_offer = 1;
    end else if (bus.cmd_valid === 1'b1 && (first < 0 || !m_fair)) begin
      m_word = bus.cmd_word; m_offer = 1; m_fair = 1;
    end else if (first >= 0) begin
      m_word = {4'h0, 4'(first + 1), m_fb[first]};
      m_dirty[first] = 0; m_offer = 1; m_fair = 0;
    end
    if (bus.fb_we === 1'b1 && 32'(bus.fb_addr) < ND) begin
      m_fb[bus.fb_addr] = bus.fb_data;
      m_dirty[bus.fb_addr] = 1'b1;
    end
    if (m_timer == RT - 1) begin
      m_timer = 0;
      foreach (m_dirty[i]) m_dirty[i] = 1'b1;
    end else begin
      m_timer++;
    end
  endtask

  // One clock: sample at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic [19:0] o, e;
    bit any_d, exp_cr;
    @(negedge clk);
    s_valid = bus.word_valid; s_data = bus.word_data; s_cready = bus.cmd_ready;
    s_init_done = bus.init_done; s_busy = bus.busy;
    any_d = 0;
    foreach (m_dirty[i]) any_d |= m_dirty[i];
    exp_cr = m_init_done && !m_offer && (bus.cmd_valid === 1'b1) && (!any_d || !m_fair);
    o = {s_valid, (s_valid === 1'b1) ? s_data : 16'h0, s_cready, s_init_done, s_busy};
    e = {m_offer, m_offer ? m_word : 16'h0, exp_cr, m_init_done, !(m_init_done && !m_offer)};
    trace.push_back('{o, e});
    if (rst_n === 1'b1 && s_valid === 1'b1 && bus.word_ready === 1'b1) obs_words.push_back(s_data);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.fb_we = 0; bus.fb_addr = 3'd0; bus.fb_data = 8'h00;
    bus.cmd_valid = 0; bus.cmd_word = 16'h0; bus.word_ready = 1;
  endtask

  task automatic reset_and_drain();
    drive_idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    trace.delete(); obs_words.delete(); exp_words.delete();
    repeat (28) cycle();
  endtask

  task automatic test_reset();
    logic [15:0] exp_seq [$];
    drive_idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    trace.delete(); obs_words.delete(); exp_words.delete();
    checks++;
    if (bus.word_valid !== 1'b0 || bus.word_data !== 16'h0 || bus.cmd_ready !== 1'b0 ||
        bus.init_done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h cr=%b id=%b busy=%b expected v=0 d=0000 cr=0 id=0 busy=1",
               bus.word_valid, bus.word_data, bus.cmd_ready, bus.init_done, bus.busy);
    end
    repeat (28) cycle();
    exp_seq = '{16'h0C00, 16'h0900, 16'h0B07, 16'h0A00, 16'h0C01};
    for (int d = 1; d <= 8; d++) exp_seq.push_back({4'h0, 4'(d), 8'h00});
    checks++;
    if (obs_words.size() != exp_seq.size()) begin
      errors++;
      $display("FAIL reset_word_count: got %0d expected %0d", obs_words.size(), exp_seq.size());
    end
    foreach (exp_seq[i]) begin
      if (i < obs_words.size()) begin
        checks++;
        if (obs_words[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL reset_word[%0d]: got %h expected %h", i, obs_words[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_init_done: got %b expected 1", bus.init_done);
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL reset_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_fb_write();
    int first_valid;
    reset_and_drain();
    obs_words.delete();
    bus.fb_we = 1; bus.fb_addr = 3'd2; bus.fb_data = 8'h5B;
    cycle();
    bus.fb_we = 0;
    first_valid = -1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (s_valid === 1'b1 && first_valid < 0) first_valid = k;
    end
    checks++;
    if (obs_words.size() != 1 || obs_words[0] !== 16'h035B) begin
      errors++;
      $display("FAIL fb_write_word: got count %0d first %h expected count 1 word 035b",
               obs_words.size(), (obs_words.size() > 0) ? obs_words[0] : 16'hxxxx);
    end
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL fb_write_latency: got %0d expected 2", first_valid);
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL fb_write_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_cmd_fair();
    int cr_count, budget;
    logic [15:0] exp_seq [4];
    reset_and_drain();
    obs_words.delete();
    bus.fb_we = 1; bus.fb_addr = 3'd0; bus.fb_data = 8'h7E;
    cycle();
    bus.fb_addr = 3'd1; bus.fb_data = 8'h30;
    bus.cmd_valid = 1; bus.cmd_word = 16'h0A0F;
    cycle();
    bus.fb_we = 0;
    cr_count = (s_cready === 1'b1) ? 1 : 0;
    budget = 0;
    while (obs_words.size() < 4 && budget < 20) begin
      cycle();
      if (s_cready === 1'b1) cr_count++;
      budget++;
    end
    bus.cmd_valid = 0;
    repeat (3) cycle();
    exp_seq = '{16'h0A0F, 16'h017E, 16'h0A0F, 16'h0230};
    checks++;
    if (obs_words.size() < 4) begin
      errors++;
      $display("FAIL cmd_fair_timeout: got %0d words expected 4", obs_words.size());
    end else begin
      foreach (exp_seq[i]) begin
        checks++;
        if (obs_words[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL cmd_fair_word[%0d]: got %h expected %h", i, obs_words[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (cr_count != 2) begin
      errors++;
      $display("FAIL cmd_fair_ready_pulses: got %0d expected 2", cr_count);
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL cmd_fair_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] w1;
    logic [7:0]  r;
    w1 = 16'($urandom);
    r  = 8'($urandom);
    reset_and_drain();
    obs_words.delete();
    bus.word_ready = 0; bus.cmd_valid = 1; bus.cmd_word = w1;
    cycle();
    bus.cmd_word = 16'($urandom);
    for (int k = 0; k < 20; k++) begin
      bus.fb_we = (k == 7); bus.fb_addr = 3'd5; bus.fb_data = r;
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_data !== w1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=%h", k, s_valid, s_data, w1);
      end
      checks++;
      if (s_cready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cmd_ready[%0d]: got %b expected 0", k, s_cready);
      end
    end
    bus.fb_we = 0; bus.cmd_valid = 0; bus.word_ready = 1;
    repeat (6) cycle();
    checks++;
    if (obs_words.size() != 2 || obs_words[0] !== w1 || obs_words[1] !== {8'h06, r}) begin
      errors++;
      $display("FAIL stall_words: got count %0d expected %h then %h", obs_words.size(), w1, {8'h06, r});
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL stall_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_grant_edge_write();
    reset_and_drain();
    obs_words.delete();
    bus.fb_we = 1; bus.fb_addr = 3'd0; bus.fb_data = 8'h22;
    cycle();
    bus.fb_data = 8'h11;
    cycle();
    bus.fb_we = 0;
    repeat (6) cycle();
    checks++;
    if (obs_words.size() != 2 || obs_words[0] !== 16'h0122 || obs_words[1] !== 16'h0111) begin
      errors++;
      $display("FAIL grant_edge_words: got count %0d expected 0122 then 0111", obs_words.size());
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL grant_edge_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    reset_and_drain();
    bus.word_ready = 0; bus.cmd_valid = 1; bus.cmd_word = 16'h0F00;
    cycle();
    bus.cmd_valid = 0;
    repeat (2) cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    checks++;
    if (bus.word_valid !== 1'b0 || bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_send_reset: got v=%b id=%b expected v=0 id=0", bus.word_valid, bus.init_done);
    end
    obs_words.delete();
    bus.word_ready = 1;
    repeat (150) cycle();
    checks++;
    if (obs_words.size() != 29) begin
      errors++;
      $display("FAIL periodic_count: got %0d expected 29", obs_words.size());
    end else begin
      checks++;
      if (obs_words[0] !== 16'h0C00) begin
        errors++;
        $display("FAIL restart_first_word: got %h expected 0c00", obs_words[0]);
      end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (obs_words[13 + k] !== {4'h0, 4'(k % 8 + 1), 8'h00}) begin
          errors++;
          $display("FAIL periodic_word[%0d]: got %h expected %h", k, obs_words[13 + k],
                   {4'h0, 4'(k % 8 + 1), 8'h00});
        end
      end
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL mid_send_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  task automatic test_random();
    reset_and_drain();
    for (int k = 0; k < 800; k++) begin
      bus.fb_we      = ($urandom_range(3) == 0);
      bus.fb_addr    = 3'($urandom);
      bus.fb_data    = 8'($urandom);
      bus.cmd_valid  = ($urandom_range(2) == 0);
      bus.cmd_word   = 16'($urandom);
      bus.word_ready = ($urandom_range(3) != 0);
      rst_n          = ($urandom_range(299) != 0);
      cycle();
    end
    rst_n = 1;
    drive_idle();
    repeat (4) cycle();
    checks++;
    if (obs_words.size() != exp_words.size()) begin
      errors++;
      $display("FAIL random_word_count: got %0d expected %0d", obs_words.size(), exp_words.size());
    end else begin
      foreach (exp_words[i]) begin
        checks++;
        if (obs_words[i] !== exp_words[i]) begin
          errors++;
          $display("FAIL random_word[%0d]: got %h expected %h", i, obs_words[i], exp_words[i]);
        end
      end
    end
    foreach (trace[i]) begin
      checks++;
      if (trace[i].obs !== trace[i].exp) begin
        errors++;
        $display("FAIL random_trace cycle %0d: got %h expected %h", i, trace[i].obs, trace[i].exp);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_fb_write();
    test_cmd_fair();
    test_stall();
    test_grant_edge_write();
    test_reset_mid_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/max7219_scheduler.md
Name: max7219_scheduler

Overview:
- Sequences and shares the MAX7219 16-bit command link between three sources: a fixed power-up init sequence, an external raw-command requester, and an internal 8-digit frame buffer refresher.
- Emits one 16-bit word at a time over a valid/ready handshake to the downstream MSB-first serializer, which handles CS/CLK/DIN.
- Sits between user logic (frame buffer writes, ad-hoc commands) and the serializer.

Parameters:
- NUM_DIGITS, 8, digits refreshed (1..8); digit d maps to register address d+1.
- INTENSITY, 4'h0, data for the intensity register (0x0A) in the init sequence.
- SCAN_LIMIT, 3'd7, data for the scan-limit register (0x0B) in the init sequence.
- REFRESH_TICKS, 32'd1350000, clk cycles between periodic full-frame refreshes; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- fb_we  in  1  frame buffer write strobe
- fb_addr  in  3  digit index for fb_we
- fb_data  in  8  segment/row pattern for fb_we
- cmd_valid  in  1  external command request
- cmd_word  in  16  external command, {opcode, data}
- cmd_ready  out  1  cmd_word accepted this cycle when cmd_valid also high
- word_valid  out  1  word_data valid to serializer
- word_data  out  16  word to serializer
- word_ready  in  1  serializer accepts word_data
- init_done  out  1  init sequence complete
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge) takes effect next edge regardless of state:
  - word_valid=0, word_data=0, cmd_ready=0, init_done=0.
  - Frame buffer cleared to 0x00; dirty[d]=1 for d<NUM_DIGITS.
  - Refresh timer=0, init index=0, fairness flag=0, state=INIT_LOAD.
  - A word in flight is abandoned; the serializer is reset by the same rst_n.
- Init words, in order:
  - 0x0C00 (shutdown)
  - 0x0900 (no decode)
  - {0x0B, 5'b0, SCAN_LIMIT}
  - {0x0A, 4'b0, INTENSITY}
  - 0x0C01 (normal operation)
- States:
  - INIT_LOAD: drive word_data=init[index], set word_valid=1, go to INIT_SEND.
  - INIT_SEND: on word_valid&word_ready, word_valid=0 and index++. After index 4, go to IDLE and set init_done=1 (stays 1 until reset); otherwise go to INIT_LOAD.
  - IDLE: arbitrate, at most one grant per cycle, then go to SEND. If nothing is pending, stay.
  - SEND: hold word_valid=1 with word_data stable until word_ready; on the accept edge, word_valid=0 and go to IDLE.
- Arbitration in IDLE:
  - Requests are cmd_valid and any_dirty.
  - Both present: cmd wins unless the fairness flag is set, in which case refresh wins.
  - Fairness flag sets when a cmd is granted and clears when a refresh is granted. Neither source can be granted twice in a row while the other waits.
  - Refresh target is the lowest-index dirty digit d; word = {4'h0, d+1 (4 bits), fb[d]}.
  - cmd_ready is combinational: 1 only in IDLE, with init_done=1, when cmd is granted. cmd_word is registered into word_data at that edge.
  - cmd_ready is 0 in every other state.
- Latency: a grant at IDLE edge n gives word_valid=1 from cycle n+1. Minimum spacing is 2 cycles per word (IDLE + SEND).
- Dirty bits:
  - fb_we writes fb[fb_addr] and sets dirty[fb_addr] in any state, including INIT and SEND.
  - Writes with fb_addr >= NUM_DIGITS are ignored.
  - The refreshed digit's dirty bit clears at the IDLE grant edge; its data is snapshotted into word_data then.
  - fb_we to the same digit on the grant edge keeps dirty set. The new data goes out in a later word; the snapshot holds the old data.
- Refresh timer:
  - Free-running after reset.
  - At REFRESH_TICKS-1 it wraps to 0 and sets dirty[d] for all d<NUM_DIGITS.
  - If this coincides with a grant-edge clear, set wins.
- Frame buffer is not read externally. External commands never alter fb or dirty.

Test Plan:
- Reset then word_ready tied 1 → init_done rises after the 5 init words 0x0C00, 0x0900, 0x0B07, 0x0A00, 0x0C01; then refresh words 0x0100 through 0x0800; each word_valid pulse lasts 1 cycle, 2 cycles apart.
- Idle, fb_we addr=2 data=0x5B → exactly one word 0x035B, word_valid 2 cycles after fb_we; dirty empty afterwards.
- cmd_valid held with cmd_word=0x0A0F while digits 0 and 1 are dirty (fb=0x7E, 0x30) → order 0x0A0F, 0x017E, 0x0A0F, 0x0230; cmd_ready pulses exactly at each cmd grant.
- word_ready held 0 for 20 cycles in SEND → word_valid and word_data stable throughout; cmd_ready=0; an fb_we during the stall is sent afterward.
- fb_we to digit 0 (0x11) on the grant edge of digit 0 (old 0x22) → 0x0122 sent, then 0x0111.
- rst_n low for 1 cycle mid-SEND, and REFRESH_TICKS=64 → word_valid=0 next cycle, init restarts at 0x0C00; every 64 cycles all 8 digits are resent.
